// File: rtl/adder_tree_pkg.sv
// Shared widths, width helpers and payload layout for the adder-tree scheduler.
// Optional feature macro used by this slice: ADDER_TREE_SCHED_RR_EN (round-robin arbitration).
package adder_tree_pkg;

  localparam int unsigned A_W_DEF  = 4;
  localparam int unsigned C_W_DEF  = 8;
  localparam int unsigned ID_W_DEF = 2;

  function automatic int unsigned sum1_width(input int unsigned a_w);
    return a_w + 1;
  endfunction

  function automatic int unsigned sum2_width(input int unsigned c_w);
    return c_w + 1;
  endfunction

  function automatic int unsigned sum3_width(input int unsigned c_w);
    return c_w + 2;
  endfunction

  // Stage payload at the default configuration (4 requesters, A_W_DEF, C_W_DEF).
  typedef struct packed {
    logic [A_W_DEF:0]    sum1;
    logic [C_W_DEF:0]    sum2;
    logic [C_W_DEF+1:0]  sum3;
    logic [ID_W_DEF-1:0] id;
  } payload_t;

endpackage

// File: rtl/adder_tree_scheduler_arb.sv
// One-hot requester arbiter: round-robin when ADDER_TREE_SCHED_RR_EN is defined,
// otherwise fixed priority with the lowest index winning and no pointer state.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o
);

  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] x);
    return x & (~x + NUM_REQ'(1));
  endfunction

`ifdef ADDER_TREE_SCHED_RR_EN
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0]    last_q;
  logic [IdxW-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] above_mask;
  logic [NUM_REQ-1:0] req_above;

  // Requesters after the pointer win first; wrap to the lowest index otherwise.
  always_comb begin
    above_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      above_mask[i] = (i > 32'(last_q));
    end
    req_above = req_i & above_mask;
    grant_o   = (|req_above) ? lowest_one(req_above) : lowest_one(req_i);
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_o[i]) begin
        gnt_idx |= IdxW'(i);
      end
    end
  end

  // adv_i is high only when the granted requester actually transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IdxW'(NUM_REQ - 1);
    end else if (adv_i) begin
      last_q <= gnt_idx;
    end
  end
`else
  logic unused_arb_inputs;
  assign unused_arb_inputs = ^{clk, rst_n, adv_i};

  always_comb begin
    grant_o = lowest_one(req_i);
  end
`endif

endmodule

// File: rtl/adder_tree_scheduler.sv
// Shares one registered two-level adder tree among NUM_REQ requesters with in-order tagged
// results. Arbitration policy is selected by ADDER_TREE_SCHED_RR_EN (see rr_arbiter).
module adder_tree_scheduler
  import adder_tree_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned A_W     = A_W_DEF,
  parameter int unsigned C_W     = C_W_DEF,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*A_W-1:0]      req_a_i,
  input  logic [NUM_REQ*A_W-1:0]      req_b_i,
  input  logic [NUM_REQ*C_W-1:0]      req_c_i,
  input  logic [NUM_REQ*C_W-1:0]      req_d_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [sum1_width(A_W)-1:0]  res_sum1_o,
  output logic [sum2_width(C_W)-1:0]  res_sum2_o,
  output logic [sum3_width(C_W)-1:0]  res_sum3_o,
  output logic [ID_W-1:0]             res_id_o,
  output logic                        busy_o
);

  localparam int unsigned S1W = sum1_width(A_W);
  localparam int unsigned S2W = sum2_width(C_W);
  localparam int unsigned S3W = sum3_width(C_W);

  typedef struct packed {
    logic [S1W-1:0]  sum1;
    logic [S2W-1:0]  sum2;
    logic [S3W-1:0]  sum3;
    logic [ID_W-1:0] id;
  } stage_t;

  logic               s1_valid_q, s2_valid_q;
  stage_t             s1_q, s1_d;
  stage_t             s2_q, s2_d;
  logic               adv1, adv2, accept;
  logic [NUM_REQ-1:0] grant;
  logic [A_W-1:0]     a_sel, b_sel;
  logic [C_W-1:0]     c_sel, d_sel;
  logic [ID_W-1:0]    id_sel;

  assign adv2 = !s2_valid_q || res_ready_i;
  assign adv1 = !s1_valid_q || adv2;
  // Gated by rst_n so no requester sees ready while the block is held in reset.
  assign accept = adv1 && (|req_valid_i) && rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_valid_i),
    .adv_i   (accept),
    .grant_o (grant)
  );

  assign req_ready_o = grant & {NUM_REQ{accept}};

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    c_sel  = '0;
    d_sel  = '0;
    id_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel  |= req_a_i[i*A_W +: A_W];
        b_sel  |= req_b_i[i*A_W +: A_W];
        c_sel  |= req_c_i[i*C_W +: C_W];
        d_sel  |= req_d_i[i*C_W +: C_W];
        id_sel |= ID_W'(i);
      end
    end
  end

  always_comb begin
    s1_d      = '0;
    s1_d.sum1 = S1W'(a_sel) + S1W'(b_sel);
    s1_d.sum2 = S2W'(c_sel) + S2W'(d_sel);
    s1_d.id   = id_sel;
  end

  always_comb begin
    s2_d      = s1_q;
    s2_d.sum3 = S3W'(s1_q.sum1) + S3W'(s1_q.sum2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_q <= s2_d;
        end
      end
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_q <= s1_d;
        end
      end
    end
  end

  // S1 never computes sum3; the field exists only to share the stage layout.
  logic unused_s1_sum3;
  assign unused_s1_sum3 = ^s1_q.sum3;

  assign res_valid_o = s2_valid_q;
  assign res_sum1_o  = s2_q.sum1;
  assign res_sum2_o  = s2_q.sum2;
  assign res_sum3_o  = s2_q.sum3;
  assign res_id_o    = s2_q.id;
  assign busy_o      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Self-checking bench for adder_tree_scheduler: vector table, directed corner sequences and
// random traffic against a transaction-level reference model.
module tb_adder_tree_scheduler;
  import adder_tree_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid, req_ready;
  logic [N*4-1:0] req_a, req_b;
  logic [N*8-1:0] req_c, req_d;
  logic         res_valid, res_ready;
  logic [4:0]   res_sum1;
  logic [8:0]   res_sum2;
  logic [9:0]   res_sum3;
  logic [1:0]   res_id;
  logic         busy;

  always #5 clk = ~clk;

  adder_tree_scheduler #(
    .NUM_REQ (N),
    .A_W     (4),
    .C_W     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_c_i     (req_c),
    .req_d_i     (req_d),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_sum1_o  (res_sum1),
    .res_sum2_o  (res_sum2),
    .res_sum3_o  (res_sum3),
    .res_id_o    (res_id),
    .busy_o      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: two pipeline slots holding expected results, plus arbitration pointer.
  logic     m_v1, m_v2;
  payload_t m_r1, m_r2;
  int       m_last;
  int       dut_g;
  int       n_xfer;

  typedef struct {
    int         idx;
    logic [3:0] a, b;
    logic [7:0] c, d;
    logic [4:0] s1;
    logic [8:0] s2;
    logic [9:0] s3;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_ops();
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    req_c = $urandom;
    req_d = $urandom;
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int last);
`ifdef ADDER_TREE_SCHED_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic payload_t mk(input int g);
    payload_t r;
    int a, b, c, d;
    a = int'(req_a[g*4 +: 4]);
    b = int'(req_b[g*4 +: 4]);
    c = int'(req_c[g*8 +: 8]);
    d = int'(req_d[g*8 +: 8]);
    r.sum1 = 5'(a + b);
    r.sum2 = 9'(c + d);
    r.sum3 = 10'(a + b + c + d);
    r.id   = 2'(g);
    return r;
  endfunction

  task automatic model_reset();
    m_v1   = 1'b0;
    m_v2   = 1'b0;
    m_r1   = '0;
    m_r2   = '0;
    m_last = N - 1;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic step();
    logic         can1, can2, acc;
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    chk("res_valid", 32'(res_valid), 32'(m_v2));
    if (m_v2) begin
      chk("res_sum1", 32'(res_sum1), 32'(m_r2.sum1));
      chk("res_sum2", 32'(res_sum2), 32'(m_r2.sum2));
      chk("res_sum3", 32'(res_sum3), 32'(m_r2.sum3));
      chk("res_id", 32'(res_id), 32'(m_r2.id));
    end
    chk("busy", 32'(busy), 32'(m_v1 | m_v2));
    can2 = !m_v2 || res_ready;
    can1 = !m_v1 || can2;
    acc  = can1 && (req_valid != '0);
    g    = model_grant(req_valid, m_last);
    exp_rdy = acc ? N'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    dut_g = -1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) dut_g = i;
    end
    if ((req_valid & req_ready) != '0) n_xfer++;
    if (can2) begin
      m_v2 = m_v1;
      m_r2 = m_r1;
    end
    if (can1) begin
      m_v1 = acc;
      if (acc) m_r1 = mk(g);
    end
    if (acc) m_last = g;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int cycles);
    req_valid = '0;
    res_ready = 1'b1;
    for (int k = 0; k < cycles; k++) step();
  endtask

  initial begin
    int   exp_rr[6];
    int   exp_fp[6];
    logic [27:0] snap;

    tbl[0] = '{0, 4'hF, 4'hF, 8'hFF, 8'hFF, 5'h1E, 9'h1FE, 10'h21C};
    tbl[1] = '{1, 4'h1, 4'h2, 8'h03, 8'h04, 5'h03, 9'h007, 10'h00A};
    tbl[2] = '{2, 4'h0, 4'h0, 8'h00, 8'h00, 5'h00, 9'h000, 10'h000};
    tbl[3] = '{3, 4'hF, 4'h1, 8'h80, 8'h80, 5'h10, 9'h100, 10'h110};
`ifdef ADDER_TREE_SCHED_RR_EN
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_fp = '{2, 0, 2, 0, 2, 0};
`else
    exp_rr = '{0, 0, 0, 0, 0, 0};
    exp_fp = '{0, 0, 0, 0, 0, 0};
`endif
    n_xfer = 0;
    model_reset();

    // Reset held with random inputs.
    rst_n = 1'b0;
    res_ready = 1'b0;
    req_valid = '0;
    rand_ops();
    #1;
    for (int k = 0; k < 3; k++) begin
      req_valid = N'($urandom);
      res_ready = 1'($urandom);
      rand_ops();
      #3;
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_sums", 32'({res_sum1, res_sum2, res_sum3, res_id}), 32'(0));
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
    end

    // First request after reset goes to its own index.
    rst_n = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b0100;
    rand_ops();
    #3;
    chk("first_grant", 32'(req_ready), 32'(4'b0100));
    step();
    drain(3);

    // Vector table: one requester at a time, operands scrambled after the transfer.
    foreach (tbl[v]) begin
      rand_ops();
      req_valid = '0;
      req_valid[tbl[v].idx] = 1'b1;
      req_a[tbl[v].idx*4 +: 4] = tbl[v].a;
      req_b[tbl[v].idx*4 +: 4] = tbl[v].b;
      req_c[tbl[v].idx*8 +: 8] = tbl[v].c;
      req_d[tbl[v].idx*8 +: 8] = tbl[v].d;
      res_ready = 1'b1;
      step();
      req_valid = '0;
      rand_ops();
      step();
      chk("vec_valid", 32'(res_valid), 32'(1));
      chk("vec_sum1", 32'(res_sum1), 32'(tbl[v].s1));
      chk("vec_sum2", 32'(res_sum2), 32'(tbl[v].s2));
      chk("vec_sum3", 32'(res_sum3), 32'(tbl[v].s3));
      chk("vec_id", 32'(res_id), 32'(tbl[v].idx));
      drain(1);
    end
    drain(2);

    // All requesters active, no backpressure.
    req_valid = '1;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      step();
      chk("rr_grant", 32'(dut_g), 32'(exp_rr[k]));
    end
    drain(3);

    // Requesters 0 and 2 contend.
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      step();
      chk("pair_grant", 32'(dut_g), 32'(exp_fp[k]));
    end
    drain(3);

    // Backpressure from an empty pipeline: two transfers fill it, then everything holds.
    res_ready = 1'b0;
    req_valid = '1;
    n_xfer = 0;
    snap = '0;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step();
      if (k == 2) snap = {res_sum1, res_sum2, res_sum3, res_id};
    end
    chk("bp_xfers", 32'(n_xfer), 32'(2));
    chk("bp_hold", 32'({res_sum1, res_sum2, res_sum3, res_id}), 32'(snap));
    chk("bp_ready", 32'(req_ready), 32'(0));
    drain(4);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    drain(3);

    // Reset between edges with both stages full.
    req_valid = '1;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      step();
    end
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(req_ready), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
